// File: rtl/cache_arbiter.sv
// Purpose: shares one physical-memory port between the I-cache and D-cache, one full line per transfer.
// Latency: grant at the sampling edge, memory request the next cycle, requester resp one cycle after pmem_resp.
// Backpressure: requests are held until *_resp; one transfer at a time, ties resolved round-robin.
//
// Ports:
//   clk, rst                                   clock, async active-high reset
//   i_read, i_address / i_rdata, i_resp        I-cache line read side
//   d_read, d_write, d_address, d_wdata /
//   d_rdata, d_resp                            D-cache line read / write-back side
//   pmem_read, pmem_write, pmem_address,
//   pmem_wdata / pmem_rdata, pmem_resp         main memory side
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t              state, state_next;
  // last_grant: 0 = I-cache, 1 = D-cache. It also names the owner of the
  // transfer in flight, so RESP uses it to steer the response pulse.
  logic                last_grant, last_grant_next;
  logic                op_write, op_write_next;
  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [LINE_W-1:0]   line_q;
  logic                i_req, d_req, grant_d;
  logic                busy;

  assign i_req = i_read;
  // d_read together with d_write is illegal; it is serviced as a write.
  assign d_req = d_read | d_write;
  // On a tie the requester that was not granted last wins.
  assign grant_d = d_req & (~i_req | ~last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      line_q     <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      op_write   <= op_write_next;
      addr_q     <= addr_next;
      // Only read transfers capture the returned line; writes leave it alone.
      if (pmem_resp && ((state == I_BUSY) || ((state == D_BUSY) && !op_write)))
        line_q <= pmem_rdata;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    op_write_next   = op_write;
    addr_next       = addr_q;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next      = D_BUSY;
          addr_next       = d_address;
          op_write_next   = d_write;
          last_grant_next = 1'b1;
        end else if (i_req) begin
          state_next      = I_BUSY;
          addr_next       = i_address;
          op_write_next   = 1'b0;
          last_grant_next = 1'b0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_next = RESP;
      end
      // Unconditional return to IDLE gives the requester one cycle to drop
      // its request before the next arbitration.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == I_BUSY) || (state == D_BUSY);

  // All outputs decode from registered state only, so reset removes the
  // memory request immediately and no output depends on pmem_resp.
  assign pmem_read    = (state == I_BUSY) || ((state == D_BUSY) && !op_write);
  assign pmem_write   = (state == D_BUSY) && op_write;
  assign pmem_address = busy ? addr_q : '0;
  assign pmem_wdata   = (state == D_BUSY) ? d_wdata : '0;

  assign i_resp  = (state == RESP) && !last_grant;
  assign d_resp  = (state == RESP) && last_grant;
  assign i_rdata = line_q;
  assign d_rdata = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] model_line;
  logic [LW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e;
  int            gap;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Waits (bounded) for the memory request, checks it every busy cycle,
  // answers after 'hold' extra cycles and queues the expected response.
  // Ends in the response cycle with the owning request dropped.
  task automatic mem_xfer(input string nm, input bit is_d, input bit exp_wr,
                          input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata,
                          input logic [LW-1:0] rdata, input int hold, output int g);
    exp_t e;
    g = 0;
    while (!(pmem_read || pmem_write) && g < 20) begin
      tick();
      g++;
    end
    if (!(pmem_read || pmem_write)) begin
      check({nm, " req_timeout"}, '0, 1);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      return;
    end
    for (int c = 0; c <= hold; c++) begin
      check({nm, " pmem_read"},    LW'(pmem_read),    LW'(!exp_wr));
      check({nm, " pmem_write"},   LW'(pmem_write),   LW'(exp_wr));
      check({nm, " pmem_address"}, LW'(pmem_address), LW'(exp_addr));
      check({nm, " pmem_wdata"},   pmem_wdata,        exp_wdata);
      if (c == hold) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        if (!exp_wr) model_line = rdata;
        e.is_d = is_d;
        e.data = model_line;
        sb.push_back(e);
      end
      tick();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = {8{$urandom()}};
    check({nm, " resp_cycle_req"}, LW'({pmem_read, pmem_write}), '0);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // Response monitor: every response pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (i_resp || d_resp)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b want none", i_resp, d_resp);
        end else begin
          e = sb.pop_front();
          if (i_resp !== !e.is_d || d_resp !== e.is_d ||
              (e.is_d ? d_rdata : i_rdata) !== e.data) begin
            errors++;
            $display("FAIL resp_%s: got i_resp=%0b d_resp=%0b rdata=%h want rdata=%h",
                     e.is_d ? "d" : "i", i_resp, d_resp, e.is_d ? d_rdata : i_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    pat_a = {8{32'hCAFE_0A0A}};
    pat_b = {8{32'h1234_BBBB}};
    pat_c = {8{32'h0C0C_5A5A}};
    pat_d = {8{32'hDEAD_D00D}};
    pat_e = {8{32'h0E0E_7777}};
    model_line = '0;
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst resp",     LW'({i_resp, d_resp}), '0);
    check("rst pmem_req", LW'({pmem_read, pmem_write}), '0);
    check("rst pmem_address", LW'(pmem_address), '0);
    check("rst pmem_wdata", pmem_wdata, '0);
    check("rst rdata",    i_rdata | d_rdata, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // First tie after reset: D wins, I follows two cycles after D's pmem_resp
    i_read = 1'b1;  i_address = 32'h0000_1100;
    d_write = 1'b1; d_address = 32'h0000_3000; d_wdata = pat_c;
    mem_xfer("tie1_d", 1'b1, 1'b1, 32'h0000_3000, pat_c, {8{$urandom()}}, 1, gap);
    check("tie1_d gap", LW'(gap), LW'(1));
    mem_xfer("tie1_i", 1'b0, 1'b0, 32'h0000_1100, '0, pat_d, 1, gap);
    check("tie1_i gap", LW'(gap), LW'(2));
    idle(2);

    // D write alone
    d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = pat_b;
    mem_xfer("dwr", 1'b1, 1'b1, 32'h0000_2040, pat_b, {8{$urandom()}}, 2, gap);
    check("dwr gap", LW'(gap), LW'(1));
    idle(2);

    // Second tie, last grant was D: I wins; D read at minimum latency
    i_read = 1'b1; i_address = 32'h0000_1200;
    d_read = 1'b1; d_address = 32'h0000_2080; d_wdata = pat_e;
    mem_xfer("tie2_i", 1'b0, 1'b0, 32'h0000_1200, '0, pat_e, 1, gap);
    check("tie2_i gap", LW'(gap), LW'(1));
    mem_xfer("tie2_d", 1'b1, 1'b0, 32'h0000_2080, pat_e, pat_a, 0, gap);
    check("tie2_d gap", LW'(gap), LW'(2));
    idle(2);

    // I read alone: pmem_read cycles 1-3, pmem_resp cycle 3, i_resp cycle 4
    i_read = 1'b1; i_address = 32'h0000_1000;
    mem_xfer("iread", 1'b0, 1'b0, 32'h0000_1000, '0, pat_a, 2, gap);
    check("iread gap", LW'(gap), LW'(1));
    idle(2);

    // d_read and d_write together: treated as a write
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_4000; d_wdata = pat_d;
    mem_xfer("drw_both", 1'b1, 1'b1, 32'h0000_4000, pat_d, {8{$urandom()}}, 1, gap);
    idle(2);

    // Spurious pmem_resp in IDLE
    pmem_resp = 1'b1; pmem_rdata = pat_c;
    tick();
    pmem_resp = 1'b0;
    check("spur pmem_req", LW'({pmem_read, pmem_write}), '0);
    tick();
    check("spur i_rdata", i_rdata, model_line);
    check("spur d_rdata", d_rdata, model_line);

    // Reset during D_BUSY
    d_write = 1'b1; d_address = 32'h0000_5000; d_wdata = pat_a;
    tick();
    check("rstmid busy pmem_write", LW'(pmem_write), LW'(1));
    #2 rst = 1'b1;
    #1;
    check("rstmid pmem_write", LW'(pmem_write), '0);
    check("rstmid pmem_address", LW'(pmem_address), '0);
    d_write = 1'b0;
    model_line = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst req", LW'({pmem_read, pmem_write, i_resp, d_resp}), '0);
    check("post_rst rdata", i_rdata, '0);
    i_read = 1'b1; i_address = 32'h0000_6000;
    mem_xfer("post_rst_i", 1'b0, 1'b0, 32'h0000_6000, '0, pat_b, 1, gap);
    check("post_rst_i gap", LW'(gap), LW'(1));
    idle(3);

    check("sb_drained", LW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
